// File: rtl/cache_refill_responder_pkg.sv
// Shared widths, FSM state encoding and response beat layout for the cache refill responder.
package cache_refill_responder_pkg;

  localparam int unsigned DATA_WIDTH   = 16;
  localparam int unsigned TAG_WIDTH    = 16;
  localparam int unsigned BLOCK_SIZE   = 4;
  localparam int unsigned OFFSET_WIDTH = 2;
  localparam int unsigned DEF_LATENCY  = 3;
  localparam int unsigned CNT_WIDTH    = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_BEAT
  } state_e;

  typedef struct packed {
    logic                    is_write;
    logic [OFFSET_WIDTH-1:0] offset;
    logic [DATA_WIDTH-1:0]   data;
    logic                    last;
  } rsp_beat_t;

  // Power-of-two block size: truncation to OFFSET_WIDTH is the modulo wrap.
  function automatic logic [OFFSET_WIDTH-1:0] wrap_offset(input logic [OFFSET_WIDTH-1:0] base,
                                                          input logic [OFFSET_WIDTH-1:0] step);
    return base + step;
  endfunction

endpackage

// File: rtl/cache_refill_responder_refill_beat_sequencer.sv
// Latency countdown and beat sequencing for one request; the top supplies data for each load.
// CRITICAL_WORD_FIRST_EN: reads start at the requested word instead of word 0.
// States: ST_IDLE waiting for request | ST_WAIT latency countdown | ST_BEAT beat on response channel
module refill_beat_sequencer
  import cache_refill_responder_pkg::*;
#(
  parameter int unsigned LATENCY = DEF_LATENCY
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    req_valid_i,
  input  logic                    req_write_i,
  input  logic [OFFSET_WIDTH-1:0] req_offset_i,
  input  logic                    rsp_ready_i,
  output logic                    req_ready_o,
  output logic                    accept_o,
  output logic                    rsp_valid_o,
  output logic                    load_o,
  output logic                    done_o,
  output logic                    load_is_write_o,
  output logic [OFFSET_WIDTH-1:0] load_offset_o,
  output logic                    load_last_o
);

  localparam logic [CNT_WIDTH-1:0]    CNT_LOAD = CNT_WIDTH'(LATENCY - 1);
  localparam logic [OFFSET_WIDTH-1:0] LAST_IDX = OFFSET_WIDTH'(BLOCK_SIZE - 1);

  state_e                  state_q, state_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic [OFFSET_WIDTH-1:0] idx_q, idx_d;
  logic [OFFSET_WIDTH-1:0] start_q, start_d;
  logic                    wr_q, wr_d;
  logic [OFFSET_WIDTH-1:0] load_idx;
  logic [OFFSET_WIDTH-1:0] read_start;

  assign req_ready_o = (state_q == ST_IDLE);
  assign accept_o    = req_ready_o & req_valid_i;
  assign rsp_valid_o = (state_q == ST_BEAT);

`ifdef CRITICAL_WORD_FIRST_EN
  assign read_start = req_offset_i;
`else
  assign read_start = '0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      start_q <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      start_q <= start_d;
      wr_q    <= wr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    start_d  = start_q;
    wr_d     = wr_q;
    load_o   = 1'b0;
    done_o   = 1'b0;
    load_idx = '0;
    case (state_q)
      ST_IDLE: begin
        if (accept_o) begin
          state_d = ST_WAIT;
          cnt_d   = CNT_LOAD;
          idx_d   = '0;
          wr_d    = req_write_i;
          start_d = req_write_i ? req_offset_i : read_start;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          load_o  = 1'b1;
          state_d = ST_BEAT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_BEAT: begin
        if (rsp_ready_i) begin
          if (wr_q || (idx_q == LAST_IDX)) begin
            done_o  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            // Next beat loads on the same edge as this handshake: no bubble.
            load_o   = 1'b1;
            load_idx = idx_q + 1'b1;
            idx_d    = load_idx;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    load_is_write_o = wr_q;
    load_offset_o   = wrap_offset(start_q, load_idx);
    load_last_o     = wr_q | (load_idx == LAST_IDX);
  end

endmodule

// File: rtl/cache_refill_responder.sv
// Backing-store responder for the cache miss/write path: block read bursts and word-write acks.
// CRITICAL_WORD_FIRST_EN (sequencer): read bursts begin at the requested word and wrap.
module cache_refill_responder
  import cache_refill_responder_pkg::*;
#(
  parameter int unsigned LATENCY = DEF_LATENCY
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [TAG_WIDTH-1:0]    req_block,
  input  logic [OFFSET_WIDTH-1:0] req_offset,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_is_write,
  output logic [OFFSET_WIDTH-1:0] rsp_offset,
  output logic [DATA_WIDTH-1:0]   rsp_data,
  output logic                    rsp_last,
  output logic [31:0]             read_req_count,
  output logic [31:0]             write_req_count
);

  // Main memory contents are deliberately left out of reset.
  logic [DATA_WIDTH-1:0]   mem [1<<TAG_WIDTH][BLOCK_SIZE];

  logic [TAG_WIDTH-1:0]    blk_q, blk_d;
  rsp_beat_t               rsp_q, rsp_d;
  logic [31:0]             rd_cnt_q, rd_cnt_d;
  logic [31:0]             wr_cnt_q, wr_cnt_d;

  logic                    accept;
  logic                    load;
  logic                    done;
  logic                    load_is_write;
  logic [OFFSET_WIDTH-1:0] load_offset;
  logic                    load_last;

  refill_beat_sequencer #(
    .LATENCY (LATENCY)
  ) u_seq (
    .clk             (clk),
    .reset_n         (reset_n),
    .req_valid_i     (req_valid),
    .req_write_i     (req_write),
    .req_offset_i    (req_offset),
    .rsp_ready_i     (rsp_ready),
    .req_ready_o     (req_ready),
    .accept_o        (accept),
    .rsp_valid_o     (rsp_valid),
    .load_o          (load),
    .done_o          (done),
    .load_is_write_o (load_is_write),
    .load_offset_o   (load_offset),
    .load_last_o     (load_last)
  );

  always_ff @(posedge clk) begin
    if (reset_n && accept && req_write) begin
      mem[req_block][req_offset] <= req_wdata;
    end
  end

  always_comb begin
    blk_d    = blk_q;
    rsp_d    = rsp_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (accept) begin
      blk_d = req_block;
      if (req_write) wr_cnt_d = wr_cnt_q + 32'd1;
      else           rd_cnt_d = rd_cnt_q + 32'd1;
    end
    if (load) begin
      rsp_d.is_write = load_is_write;
      rsp_d.offset   = load_offset;
      rsp_d.last     = load_last;
      rsp_d.data     = load_is_write ? '0 : mem[blk_q][load_offset];
    end else if (done) begin
      rsp_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      blk_q    <= '0;
      rsp_q    <= '0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      blk_q    <= blk_d;
      rsp_q    <= rsp_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign rsp_is_write    = rsp_q.is_write;
  assign rsp_offset      = rsp_q.offset;
  assign rsp_data        = rsp_q.data;
  assign rsp_last        = rsp_q.last;
  assign read_req_count  = rd_cnt_q;
  assign write_req_count = wr_cnt_q;

endmodule

// File: tb/tb_cache_refill_responder.sv
// Self-checking bench for cache_refill_responder: directed scenarios plus random traffic
// against a transaction-level memory model.
module tb_cache_refill_responder;
  import cache_refill_responder_pkg::*;

  localparam int LAT = 3;
`ifdef CRITICAL_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    reset_n;
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_write;
  logic [TAG_WIDTH-1:0]    req_block;
  logic [OFFSET_WIDTH-1:0] req_offset;
  logic [DATA_WIDTH-1:0]   req_wdata;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic                    rsp_is_write;
  logic [OFFSET_WIDTH-1:0] rsp_offset;
  logic [DATA_WIDTH-1:0]   rsp_data;
  logic                    rsp_last;
  logic [31:0]             read_req_count;
  logic [31:0]             write_req_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_WIDTH-1:0] wmodel [int];
  int unsigned exp_rd = 0;
  int unsigned exp_wr = 0;

  always #5 clk = ~clk;

  cache_refill_responder #(.LATENCY(LAT)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_write       (req_write),
    .req_block       (req_block),
    .req_offset      (req_offset),
    .req_wdata       (req_wdata),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_is_write    (rsp_is_write),
    .rsp_offset      (rsp_offset),
    .rsp_data        (rsp_data),
    .rsp_last        (rsp_last),
    .read_req_count  (read_req_count),
    .write_req_count (write_req_count)
  );

  function automatic logic [DATA_WIDTH-1:0] exp_word(input int b, input int w);
    int key;
    key = b * BLOCK_SIZE + w;
    if (wmodel.exists(key)) return wmodel[key];
    return DATA_WIDTH'(key);
  endfunction

  // One complete request/response exchange, checked cycle by cycle against the model.
  task automatic run_txn(input bit wr, input int blk, input int off, input logic [15:0] wdata,
                         input bit rand_ready, input int stall_beat, input bit keep_valid,
                         input int reset_at, output bit aborted);
    int waited;
    int start;
    int nbeats;
    int k;
    int stall_run;
    int eoff;
    logic [DATA_WIDTH-1:0] edata;
    bit elast;
    bit r;
    waited = 0;
    aborted = 1'b0;
    while (req_ready !== 1'b1 && waited < 300) begin
      @(posedge clk); #1;
      waited++;
    end
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL wait_ready: req_ready=%b after %0d cycles, required 1", req_ready, waited);
      return;
    end
    req_valid  = 1'b1;
    req_write  = wr;
    req_block  = TAG_WIDTH'(blk);
    req_offset = OFFSET_WIDTH'(off);
    req_wdata  = wdata;
    @(posedge clk); #1;
    if (!keep_valid) req_valid = 1'b0;
    if (wr) begin
      exp_wr++;
      wmodel[blk * BLOCK_SIZE + off] = wdata;
    end else begin
      exp_rd++;
    end
    n_checks++;
    if (read_req_count !== exp_rd) begin n_fail++; $display("FAIL read_count: got %0d, required %0d", read_req_count, exp_rd); end
    n_checks++;
    if (write_req_count !== exp_wr) begin n_fail++; $display("FAIL write_count: got %0d, required %0d", write_req_count, exp_wr); end
    for (int i = 0; i < LAT; i++) begin
      n_checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL latency_gap: cycle %0d after accept rsp_valid=%b req_ready=%b, required 0/0", i, rsp_valid, req_ready);
      end
      @(posedge clk); #1;
    end
    start  = (wr || CWF) ? off : 0;
    nbeats = wr ? 1 : BLOCK_SIZE;
    k = 0;
    stall_run = 0;
    while (k < nbeats) begin
      eoff  = (start + k) % BLOCK_SIZE;
      edata = wr ? '0 : exp_word(blk, eoff);
      elast = wr ? 1'b1 : (k == BLOCK_SIZE - 1);
      n_checks++;
      if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL beat_valid: beat %0d rsp_valid=%b, required 1", k, rsp_valid); end
      n_checks++;
      if (rsp_is_write !== wr) begin n_fail++; $display("FAIL beat_is_write: beat %0d got %b, required %b", k, rsp_is_write, wr); end
      n_checks++;
      if (rsp_offset !== OFFSET_WIDTH'(eoff)) begin n_fail++; $display("FAIL beat_offset: beat %0d got %0d, required %0d", k, rsp_offset, eoff); end
      n_checks++;
      if (rsp_data !== edata) begin n_fail++; $display("FAIL beat_data: beat %0d got 0x%h, required 0x%h", k, rsp_data, edata); end
      n_checks++;
      if (rsp_last !== elast) begin n_fail++; $display("FAIL beat_last: beat %0d got %b, required %b", k, rsp_last, elast); end
      n_checks++;
      if (req_ready !== 1'b0) begin n_fail++; $display("FAIL busy_ready: beat %0d req_ready=%b, required 0", k, req_ready); end
      if (k == reset_at) begin
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        exp_rd = 0;
        exp_wr = 0;
        aborted = 1'b1;
        rsp_ready = 1'b1;
        return;
      end
      if (k == stall_beat && stall_run < 2) r = 1'b0;
      else if (rand_ready && stall_run < 4) r = ($urandom_range(0, 99) < 65);
      else r = 1'b1;
      rsp_ready = r;
      @(posedge clk); #1;
      if (r) begin
        k++;
        stall_run = 0;
      end else begin
        stall_run++;
      end
    end
    rsp_ready = 1'b1;
    n_checks++;
    if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL post_valid: rsp_valid=%b after final beat, required 0", rsp_valid); end
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL post_ready: req_ready=%b after final beat, required 1", req_ready); end
    n_checks++;
    if (read_req_count !== exp_rd || write_req_count !== exp_wr) begin
      n_fail++;
      $display("FAIL post_counts: rd=%0d wr=%0d, required rd=%0d wr=%0d", read_req_count, write_req_count, exp_rd, exp_wr);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    n_checks++;
    if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b, required 0", rsp_valid); end
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b, required 1", req_ready); end
    n_checks++;
    if (rsp_is_write !== 1'b0 || rsp_last !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: is_write=%b last=%b, required 0/0", rsp_is_write, rsp_last);
    end
    n_checks++;
    if (rsp_offset !== '0 || rsp_data !== '0) begin
      n_fail++;
      $display("FAIL reset_payload: offset=%0d data=0x%h, required 0/0", rsp_offset, rsp_data);
    end
    n_checks++;
    if (read_req_count !== 32'd0 || write_req_count !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_counts: rd=%0d wr=%0d, required 0/0", read_req_count, write_req_count);
    end
  endtask

  task automatic test_read_basic();
    bit ab;
    run_txn(1'b0, 'h0010, 1, 16'h0, 1'b0, -1, 1'b0, -1, ab);
    n_checks++;
    if (read_req_count !== 32'd1) begin n_fail++; $display("FAIL basic_read_count: got %0d, required 1", read_req_count); end
  endtask

  task automatic test_backpressure();
    bit ab;
    run_txn(1'b0, 'h0010, 1, 16'h0, 1'b0, 2, 1'b0, -1, ab);
  endtask

  task automatic test_write();
    bit ab;
    run_txn(1'b1, 'h0030, 3, 16'hCCCC, 1'b0, -1, 1'b0, -1, ab);
    run_txn(1'b0, 'h0030, 0, 16'h0, 1'b0, -1, 1'b0, -1, ab);
    n_checks++;
    if (write_req_count !== 32'd1) begin n_fail++; $display("FAIL write_count_one: got %0d, required 1", write_req_count); end
  endtask

  task automatic test_back_to_back();
    bit ab;
    run_txn(1'b0, 'h0005, 2, 16'h0, 1'b0, -1, 1'b1, -1, ab);
    run_txn(1'b1, 'h0006, 1, 16'hBEEF, 1'b0, -1, 1'b1, -1, ab);
    run_txn(1'b0, 'h0006, 3, 16'h0, 1'b0, 1, 1'b0, -1, ab);
  endtask

  task automatic test_random();
    bit ab;
    bit wr;
    int blk;
    for (int n = 0; n < 40; n++) begin
      wr  = ($urandom_range(0, 99) < 40);
      blk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 15));
      run_txn(wr, blk, int'($urandom_range(0, BLOCK_SIZE - 1)), 16'($urandom), 1'b1, -1, 1'b0, -1, ab);
    end
  endtask

  task automatic test_reset_mid_burst();
    bit ab;
    run_txn(1'b0, 'h0007, 0, 16'h0, 1'b0, -1, 1'b0, 1, ab);
    n_checks++;
    if (ab !== 1'b1) begin n_fail++; $display("FAIL midreset_reached: aborted=%b, required 1", ab); end
    n_checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_handshake: rsp_valid=%b req_ready=%b, required 0/1", rsp_valid, req_ready);
    end
    n_checks++;
    if (read_req_count !== 32'd0 || write_req_count !== 32'd0) begin
      n_fail++;
      $display("FAIL midreset_counts: rd=%0d wr=%0d, required 0/0", read_req_count, write_req_count);
    end
    run_txn(1'b0, 'h0030, 2, 16'h0, 1'b0, -1, 1'b0, -1, ab);
  endtask

  initial begin
    reset_n    = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_block  = '0;
    req_offset = '0;
    req_wdata  = '0;
    rsp_ready  = 1'b1;
    for (int b = 0; b < (1 << TAG_WIDTH); b++) begin
      for (int w = 0; w < BLOCK_SIZE; w++) begin
        dut.mem[b][w] = DATA_WIDTH'(b * BLOCK_SIZE + w);
      end
    end
    test_reset();
    test_read_basic();
    test_backpressure();
    test_write();
    test_back_to_back();
    test_random();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
